// File: rtl/bcd_to_hex_converter.sv
// bcd_to_hex_converter
//
// Turns six packed-decimal BCD digits into a binary value. The digits are
// handled one per clock, most significant first, with acc = acc*10 + digit.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        conversion request (only looked at in IDLE)
//   bcd_digit_0..bcd_digit_5  BCD digits, units .. hundred-thousands
//   busy         conversion in progress
//   done         one-cycle pulse: hex_number/invalid have just been updated
//   invalid      the last conversion saw a digit > 9 (its result is 0)
//   hex_number   binary result, held between conversions
//   state_dbg    current FSM state (0 = IDLE, 1 = CONVERT)
//
// Handshake: a conversion is accepted on the rising edge where start = 1
// and the block is idle (busy = 0). All six digits are captured on that
// edge, so they may change afterwards. busy stays high for exactly 6
// cycles. done pulses for one cycle, 6 clocks after the accepting edge.
// A start that arrives while busy is dropped; it is not queued. If start is
// held high, it is sampled again in the done cycle, which gives one result
// every 7 cycles.
module bcd_to_hex_converter #(
  parameter int BIN_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       bcd_digit_0,
  input  logic [3:0]       bcd_digit_1,
  input  logic [3:0]       bcd_digit_2,
  input  logic [3:0]       bcd_digit_3,
  input  logic [3:0]       bcd_digit_4,
  input  logic [3:0]       bcd_digit_5,
  output logic             busy,
  output logic             done,
  output logic             invalid,
  output logic [BIN_W-1:0] hex_number,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic [5:0][3:0]    dig_q, dig_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               invalid_q, invalid_d;
  logic [BIN_W-1:0]   hex_q, hex_d;

  logic [3:0]         cur_digit;
  logic [BIN_W+3:0]   acc_ext;
  logic [BIN_W+3:0]   acc_x10;
  logic [BIN_W-1:0]   acc_next;

  // Digit currently being folded in. Index values 6 and 7 never occur.
  always_comb begin
    cur_digit = 4'd0;
    case (idx_q)
      3'd0:    cur_digit = dig_q[0];
      3'd1:    cur_digit = dig_q[1];
      3'd2:    cur_digit = dig_q[2];
      3'd3:    cur_digit = dig_q[3];
      3'd4:    cur_digit = dig_q[4];
      3'd5:    cur_digit = dig_q[5];
      default: cur_digit = 4'd0;
    endcase
  end

  // acc*10 is built as acc*8 + acc*2 at four extra bits and then truncated.
  // With valid digits no intermediate value goes above 999999. With an
  // invalid digit the value may wrap, but that result is discarded.
  assign acc_ext  = {4'd0, acc_q};
  assign acc_x10  = (acc_ext << 3) + (acc_ext << 1);
  assign acc_next = acc_x10[BIN_W-1:0] + {{(BIN_W-4){1'b0}}, cur_digit};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    dig_d     = dig_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;
    hex_d     = hex_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dig_d   = {bcd_digit_5, bcd_digit_4, bcd_digit_3,
                     bcd_digit_2, bcd_digit_1, bcd_digit_0};
          err_d   = (bcd_digit_5 > 4'd9) || (bcd_digit_4 > 4'd9) ||
                    (bcd_digit_3 > 4'd9) || (bcd_digit_2 > 4'd9) ||
                    (bcd_digit_1 > 4'd9) || (bcd_digit_0 > 4'd9);
          acc_d   = '0;
          idx_d   = 3'd5;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        acc_d = acc_next;
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          hex_d     = err_q ? '0 : acc_next;
          invalid_d = err_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          idx_d     = 3'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= 3'd0;
      dig_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      hex_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      dig_q     <= dig_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      hex_q     <= hex_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign invalid    = invalid_q;
  assign hex_number = hex_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/bcd_to_hex_converter.md
Name: bcd_to_hex_converter

Overview:
- Sequential converter from six packed-decimal BCD digits to a 20-bit binary value.
- Inverse of the existing binary-to-BCD display path.
- Used where decimal values entered by the user (switch or keypad digits) must be turned into binary for counters, timers and comparators.
- Processes one digit per clock, most significant first: acc = acc*10 + digit. A start/busy/done handshake frames each conversion.

Parameters:
- BIN_W, 20: width of the binary result. Must be >= 20; 999999 needs 20 bits. Bits above 19 are always 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion. Sampled only in IDLE.
- bcd_digit_0  input  4  BCD units digit.
- bcd_digit_1  input  4  BCD tens digit.
- bcd_digit_2  input  4  BCD hundreds digit.
- bcd_digit_3  input  4  BCD thousands digit.
- bcd_digit_4  input  4  BCD ten-thousands digit.
- bcd_digit_5  input  4  BCD hundred-thousands digit.
- busy  output  1  conversion in progress.
- done  output  1  single-cycle pulse: result valid and updated.
- invalid  output  1  last conversion saw a digit > 9. Valid from the done pulse until the next done.
- hex_number  output  BIN_W  binary result. Holds its value between conversions.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state = IDLE; busy = 0; done = 0; invalid = 0; hex_number = 0.
  - Accumulator, digit index and captured digits are cleared.
  - Any conversion in progress is abandoned; no done is produced for it.
- States: IDLE, CONVERT.
- IDLE:
  - On the edge where start = 1 (call it E0), capture all six digits into internal registers, acc <= 0, idx <= 5, busy <= 1, go to CONVERT.
  - Capture err <= 1 if any captured digit > 9.
  - Digit inputs may change freely after E0.
- CONVERT, one digit per edge (E1..E6):
  - acc <= acc*10 + digit[idx]; idx <= idx - 1.
  - acc*10 is formed as (acc<<3) + (acc<<1) at BIN_W+4 bits, then truncated to BIN_W.
  - No intermediate value exceeds 999999 when all digits are valid.
  - At E6 (idx == 0):
    - hex_number <= err ? 0 : final acc.
    - invalid <= err; done <= 1; busy <= 0; return to IDLE.
- Latency:
  - done is high in the cycle after E6, i.e. 6 clocks after the start-sampling edge.
  - busy is high for exactly 6 cycles.
- done:
  - Registered pulse, exactly 1 cycle wide; cleared on the next edge.
  - Never asserted without a preceding accepted start.
- start while busy: ignored and not queued. The captured operands are unaffected.
- start held high continuously: back-to-back conversions.
  - start is re-sampled in the done cycle (state IDLE), so a new E0 coincides with the done pulse.
  - Throughput is one result per 7 cycles.
- Invalid digits (0xA–0xF):
  - Conversion still runs its full 6 cycles (constant latency).
  - Result is forced to 0 and invalid = 1.
- hex_number and invalid change only at a done edge or at reset.
- Bits [BIN_W-1:20] of hex_number are always 0.

Test Plan:
- Reset, then digits 1,2,3,4,5,6 (d5..d0), start for 1 cycle:
  - busy = 1 for 6 cycles.
  - done pulses 6 clocks after the start edge.
  - hex_number = 0x1E240, invalid = 0.
- Digits 9,9,9,9,9,9 -> hex_number = 0xF423F. Digits 0,0,0,0,0,0 -> hex_number = 0x00000, done still pulses.
- Digits 0,0,0,0,A,7 -> after 6 cycles done = 1, invalid = 1, hex_number = 0. A following 0,0,0,0,4,2 -> hex_number = 0x0002A, invalid = 0.
- Start 123456, change digits to 000001 and pulse start again at cycle 3 -> second start ignored; result 0x1E240; exactly one done pulse.
- start held high with digits 000010 -> done pulses every 7 cycles, each with hex_number = 0x0000A.
- Start 999999, assert reset at cycle 3 -> all outputs 0 immediately. No done follows. Next start with 000007 -> hex_number = 0x00007.
